// File: rtl/cdb_arbiter_if.sv
// Write-back handshake and common data bus signals between functional units
// and the CDB arbiter.
interface cdb_arbiter_if #(
   parameter int unsigned NUM_UNITS = 4,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned TAG_W     = 4,
   parameter int unsigned SRC_W     = 2
);
   logic [NUM_UNITS-1:0]        require;
   logic [NUM_UNITS*DATA_W-1:0] resultIn;
   logic [NUM_UNITS*TAG_W-1:0]  tagIn;
   logic                        stall;
   logic                        flush;
   logic [NUM_UNITS-1:0]        requireAC;
   logic                        cdbValid;
   logic [DATA_W-1:0]           cdbData;
   logic [TAG_W-1:0]            cdbTag;
   logic [SRC_W-1:0]            cdbSrc;
   logic [15:0]                 cdbCount;

   modport master (
      output require, resultIn, tagIn, stall, flush,
      input  requireAC, cdbValid, cdbData, cdbTag, cdbSrc, cdbCount
   );

   modport slave (
      input  require, resultIn, tagIn, stall, flush,
      output requireAC, cdbValid, cdbData, cdbTag, cdbSrc, cdbCount
   );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin write-back arbiter: grants one functional unit per cycle and
// broadcasts its registered result and tag on the CDB for one cycle.
module cdb_arbiter #(
   parameter int unsigned NUM_UNITS = 4,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned TAG_W     = 4,
   parameter int unsigned SRC_W     = 2
) (
   input logic         clk,
   input logic         nRST,
   cdb_arbiter_if.slave bus
);
   logic [SRC_W-1:0]     ptr;
   logic [SRC_W-1:0]     gidx;
   logic [SRC_W-1:0]     ptr_next;
   int unsigned          gsel;
   logic                 found;
   logic                 grant;
   logic [NUM_UNITS-1:0] req_ac;

   logic                 valid_q;
   logic [DATA_W-1:0]    data_q;
   logic [TAG_W-1:0]     tag_q;
   logic [SRC_W-1:0]     src_q;
   logic [15:0]          count_q;

   // Scan from ptr upward with wraparound; first requester found wins.
   always_comb begin
      int unsigned idx;
      found = 1'b0;
      gsel  = 0;
      for (int unsigned k = 0; k < NUM_UNITS; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_UNITS) idx = idx - NUM_UNITS;
         if (!found && bus.require[idx]) begin
            found = 1'b1;
            gsel  = idx;
         end
      end
   end

   always_comb begin
      gidx   = SRC_W'(gsel);
      grant  = found && !bus.stall && !bus.flush && nRST;
      req_ac = '0;
      if (grant) req_ac[gsel] = 1'b1;
      ptr_next = (gidx == SRC_W'(NUM_UNITS - 1)) ? '0 : gidx + 1'b1;
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         ptr     <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         tag_q   <= '0;
         src_q   <= '0;
         count_q <= '0;
      end else if (grant) begin
         ptr     <= ptr_next;
         valid_q <= 1'b1;
         data_q  <= bus.resultIn[gsel*DATA_W +: DATA_W];
         tag_q   <= bus.tagIn[gsel*TAG_W +: TAG_W];
         src_q   <= gidx;
         count_q <= count_q + 16'd1;
      end else begin
         valid_q <= 1'b0;
      end
   end

   assign bus.requireAC = req_ac;
   assign bus.cdbValid  = valid_q;
   assign bus.cdbData   = data_q;
   assign bus.cdbTag    = tag_q;
   assign bus.cdbSrc    = src_q;
   assign bus.cdbCount  = count_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed, table-driven bench for cdb_arbiter with four units.
module tb_cdb_arbiter;
   logic clk;
   logic nRST;

   cdb_arbiter_if #(.NUM_UNITS(4), .DATA_W(32), .TAG_W(4), .SRC_W(2)) bus ();

   cdb_arbiter #(.NUM_UNITS(4), .DATA_W(32), .TAG_W(4), .SRC_W(2)) dut (
      .clk  (clk),
      .nRST (nRST),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  req;
      logic        stall;
      logic        flush;
      logic [3:0]  ac;
      logic        valid;
      logic [1:0]  src;
      logic [15:0] cnt;
   } vec_t;

   vec_t        vt[$];
   logic [31:0] res_val[4];
   logic [3:0]  tag_val[4];
   int          n_pass  = 0;
   int          n_total = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic add(input logic [3:0] req, input logic stall, input logic flush,
                      input logic [3:0] ac, input logic valid, input logic [1:0] src,
                      input logic [15:0] cnt);
      vec_t v;
      v.req = req; v.stall = stall; v.flush = flush;
      v.ac = ac; v.valid = valid; v.src = src; v.cnt = cnt;
      vt.push_back(v);
   endtask

   initial begin
      int bad_onehot;
      res_val[0] = 32'hA5A5_0001; tag_val[0] = 4'h9;
      res_val[1] = 32'hC0DE_0011; tag_val[1] = 4'hC;
      res_val[2] = 32'h0000_1234; tag_val[2] = 4'h5;
      res_val[3] = 32'hFFFF_FF33; tag_val[3] = 4'hE;

      // round robin x2, then single requester, wrap priority, stall/flush
      add(4'b1111, 0, 0, 4'b0001, 1, 2'd0, 16'd1);
      add(4'b1111, 0, 0, 4'b0010, 1, 2'd1, 16'd2);
      add(4'b1111, 0, 0, 4'b0100, 1, 2'd2, 16'd3);
      add(4'b1111, 0, 0, 4'b1000, 1, 2'd3, 16'd4);
      add(4'b1111, 0, 0, 4'b0001, 1, 2'd0, 16'd5);
      add(4'b1111, 0, 0, 4'b0010, 1, 2'd1, 16'd6);
      add(4'b1111, 0, 0, 4'b0100, 1, 2'd2, 16'd7);
      add(4'b1111, 0, 0, 4'b1000, 1, 2'd3, 16'd8);
      add(4'b0000, 0, 0, 4'b0000, 0, 2'd3, 16'd8);
      add(4'b0100, 0, 0, 4'b0100, 1, 2'd2, 16'd9);
      add(4'b0000, 0, 0, 4'b0000, 0, 2'd2, 16'd9);
      add(4'b1000, 0, 0, 4'b1000, 1, 2'd3, 16'd10);
      add(4'b1001, 0, 0, 4'b0001, 1, 2'd0, 16'd11);
      add(4'b1000, 0, 0, 4'b1000, 1, 2'd3, 16'd12);
      add(4'b0010, 1, 0, 4'b0000, 0, 2'd3, 16'd12);
      add(4'b0010, 1, 0, 4'b0000, 0, 2'd3, 16'd12);
      add(4'b0010, 1, 0, 4'b0000, 0, 2'd3, 16'd12);
      add(4'b0010, 0, 0, 4'b0010, 1, 2'd1, 16'd13);
      add(4'b0001, 0, 1, 4'b0000, 0, 2'd1, 16'd13);
      add(4'b1111, 1, 1, 4'b0000, 0, 2'd1, 16'd13);
      add(4'b0011, 0, 0, 4'b0001, 1, 2'd0, 16'd14);
      add(4'b0011, 0, 0, 4'b0010, 1, 2'd1, 16'd15);

      nRST        = 1'b0;
      bus.require = 4'b1111;
      bus.stall   = 1'b0;
      bus.flush   = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.resultIn[i*32 +: 32] = res_val[i];
         bus.tagIn[i*4 +: 4]      = tag_val[i];
      end

      // Reset held across edges with everyone requesting
      #2;
      chk("rst_ac", 64'(bus.requireAC), 64'h0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 64'(bus.cdbValid), 64'h0);
      chk("rst_count", 64'(bus.cdbCount), 64'h0);
      chk("rst_data",  64'(bus.cdbData),  64'h0);
      chk("rst_src",   64'(bus.cdbSrc),   64'h0);
      chk("rst_ac2",   64'(bus.requireAC), 64'h0);
      #2 nRST = 1'b1;

      foreach (vt[n]) begin
         bus.require = vt[n].req;
         bus.stall   = vt[n].stall;
         bus.flush   = vt[n].flush;
         #2;
         chk($sformatf("v%0d_ac", n), 64'(bus.requireAC), 64'(vt[n].ac));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_valid", n), 64'(bus.cdbValid), 64'(vt[n].valid));
         chk($sformatf("v%0d_src", n),   64'(bus.cdbSrc),   64'(vt[n].src));
         chk($sformatf("v%0d_count", n), 64'(bus.cdbCount), 64'(vt[n].cnt));
         chk($sformatf("v%0d_data", n),  64'(bus.cdbData),  64'(res_val[vt[n].src]));
         chk($sformatf("v%0d_tag", n),   64'(bus.cdbTag),   64'(tag_val[vt[n].src]));
      end

      // Preload the counter to 0xFFFF, then one more grant wraps it
      bad_onehot  = 0;
      bus.require = 4'b1111;
      bus.stall   = 1'b0;
      bus.flush   = 1'b0;
      repeat (65535 - 15) begin
         #2;
         if (!$onehot(bus.requireAC)) bad_onehot++;
         @(posedge clk);
         #1;
      end
      chk("preload_onehot", 64'(bad_onehot), 64'h0);
      chk("preload_count", 64'(bus.cdbCount), 64'hFFFF);
      @(posedge clk);
      #1;
      chk("wrap_count", 64'(bus.cdbCount), 64'h0);
      chk("wrap_valid", 64'(bus.cdbValid), 64'h1);

      // Asynchronous reset pulse between edges during a broadcast
      #2 nRST = 1'b0;
      #1;
      chk("arst_valid", 64'(bus.cdbValid), 64'h0);
      chk("arst_count", 64'(bus.cdbCount), 64'h0);
      chk("arst_data",  64'(bus.cdbData),  64'h0);
      chk("arst_ac",    64'(bus.requireAC), 64'h0);
      #1 nRST = 1'b1;
      #1;
      chk("post_arst_ac", 64'(bus.requireAC), 64'h1);
      @(posedge clk);
      #1;
      chk("post_arst_src",   64'(bus.cdbSrc),   64'h0);
      chk("post_arst_count", 64'(bus.cdbCount), 64'h1);
      chk("post_arst_data",  64'(bus.cdbData),  64'(res_val[0]));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
